// File: rtl/skid_fifo.sv
// Elastic valid/ready FIFO: registered output stage plus a (DEPTH-1)-entry circular store.
// Every output is driven from a flop, so neither handshake has a combinational path through the buffer.
module skid_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = 3
) (
  input  logic                       i_clock,
  input  logic                       i_aresetn,
  input  logic                       i_clear,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_input_valid,
  output logic                       o_input_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_output_valid,
  input  logic                       i_output_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SLOTS = DEPTH - 1;

  logic [DATA_WIDTH-1:0] store [SLOTS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         next_count;
  logic [CW-1:0]         store_cnt;
  logic                  accept;
  logic                  transmit;
  logic                  store_empty;
  logic                  pop;
  logic                  push;
  logic                  load_out;

  // Store has DEPTH-1 slots, so wrap is an explicit compare rather than a mask.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SLOTS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    accept      = i_input_valid && o_input_ready;
    transmit    = o_output_valid && i_output_ready;
    store_cnt   = o_count - CW'(o_output_valid);
    store_empty = (store_cnt == '0);
    next_count  = o_count;
    if (accept && !transmit)
      next_count = o_count + CW'(1);
    else if (transmit && !accept)
      next_count = o_count - CW'(1);
    // Store head refills the output on transmit; otherwise new data bypasses
    // the store whenever the output register is (or is becoming) free.
    pop      = transmit && !store_empty;
    push     = accept && o_output_valid && !(transmit && store_empty);
    load_out = pop || (accept && !push);
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_count        <= '0;
      o_input_ready  <= 1'b0;
      o_output_valid <= 1'b0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else if (i_clear) begin
      o_count        <= '0;
      o_input_ready  <= 1'b0;
      o_output_valid <= 1'b0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      o_count        <= next_count;
      o_input_ready  <= (next_count != CW'(DEPTH));
      o_output_valid <= (next_count != '0);
      o_empty        <= (next_count == '0);
      o_full         <= (next_count == CW'(DEPTH));
      o_almost_full  <= (next_count >= CW'(ALMOST_FULL_LEVEL));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_data <= '0;
      for (int i = 0; i < SLOTS; i++) store[i] <= '0;
    end else if (i_clear) begin
      o_data <= '0;
      for (int i = 0; i < SLOTS; i++) store[i] <= '0;
    end else begin
      if (load_out) o_data <= pop ? store[rd_ptr] : i_data;
      if (push)     store[wr_ptr] <= i_data;
    end
  end

endmodule

// File: tb/tb_skid_fifo.sv
// Directed plus randomized bench for skid_fifo against a queue-based reference model.
module tb_skid_fifo;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int AFL = 3;
  localparam int CW  = $clog2(DEP+1);

  logic          i_clock = 1'b0;
  logic          i_aresetn = 1'b0;
  logic          i_clear = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_input_valid = 1'b0;
  logic          o_input_ready;
  logic [DW-1:0] o_data;
  logic          o_output_valid;
  logic          i_output_ready = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_empty, o_full, o_almost_full;

  skid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_LEVEL(AFL)) dut (
    .i_clock(i_clock), .i_aresetn(i_aresetn), .i_clear(i_clear), .i_data(i_data),
    .i_input_valid(i_input_valid), .o_input_ready(o_input_ready), .o_data(o_data),
    .o_output_valid(o_output_valid), .i_output_ready(i_output_ready), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full), .o_almost_full(o_almost_full));

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int failures = 0;
  int tx_total = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_data = '0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] rx[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, 64'(o_input_ready), 64'(m_ready));
    check({tag, ".valid"}, 64'(o_output_valid), 64'(q.size() != 0));
    check({tag, ".data"},  64'(o_data), 64'(q.size() != 0 ? q[0] : last_data));
    check({tag, ".count"}, 64'(o_count), 64'(q.size()));
    check({tag, ".empty"}, 64'(o_empty), 64'(q.size() == 0));
    check({tag, ".full"},  64'(o_full), 64'(q.size() == DEP));
    check({tag, ".afull"}, 64'(o_almost_full), 64'(q.size() >= AFL));
  endtask

  task automatic model_reset();
    q.delete();
    last_data = '0;
    m_ready = 1'b0;
  endtask

  // Drive one cycle (called #1 after a rising edge), advance the model, check #1 after the next edge.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic r, input logic clr);
    logic acc, tx;
    i_input_valid  = v;
    i_data         = d;
    i_output_ready = r;
    i_clear        = clr;
    acc = v && m_ready;
    tx  = (q.size() != 0) && r;
    @(posedge i_clock);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      if (tx) begin
        last_data = q.pop_front();
        rx.push_back(last_data);
        tx_total++;
      end
      if (acc) q.push_back(d);
      m_ready = (q.size() != DEP);
    end
    i_clear = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int sent;
    int tx_before;
    // Reset held for 3 cycles, then idle
    model_reset();
    repeat (3) begin
      @(posedge i_clock);
      #1;
      check_all("reset");
    end
    i_aresetn = 1'b1;
    cycle("post_reset", 1'b0, '0, 1'b0, 1'b0);
    check("post_reset.ready_up", 64'(o_input_ready), 64'd1);

    // Fill to full with back-pressure, then offer a 5th word
    for (int i = 0; i < DEP; i++) cycle("fill", 1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
    check("fill.full", 64'(o_full), 64'd1);
    cycle("overflow", 1'b1, DW'(32'hA4), 1'b0, 1'b0);
    check("overflow.count", 64'(o_count), 64'(DEP));

    // Drain
    rx.delete();
    for (int i = 0; i < DEP + 1; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    check("drain.n", 64'(rx.size()), 64'(DEP));
    for (int i = 0; i < rx.size(); i++) check("drain.order", 64'(rx[i]), 64'(32'hA0 + i));

    // Randomized streaming of 0..999
    rx.delete();
    sent = 0;
    for (int c = 0; c < 20000 && rx.size() < 1000; c++) begin
      logic v;
      v = (sent < 1000) && ($urandom % 2 == 1);
      if (v && m_ready) begin
        cycle("stream", 1'b1, DW'(sent), 1'($urandom % 2), 1'b0);
        sent++;
      end else begin
        cycle("stream", v, DW'(sent), 1'($urandom % 2), 1'b0);
      end
    end
    check("stream.n", 64'(rx.size()), 64'd1000);
    for (int i = 0; i < rx.size(); i++)
      if (rx[i] !== DW'(i)) check("stream.order", 64'(rx[i]), 64'(i));

    // Simultaneous accept and transmit at count 2, then 20 cycles full streaming
    cycle("sim.fill", 1'b1, DW'(32'h100), 1'b0, 1'b0);
    cycle("sim.fill", 1'b1, DW'(32'h101), 1'b0, 1'b0);
    cycle("sim.both", 1'b1, DW'(32'h102), 1'b1, 1'b0);
    check("sim.count2", 64'(o_count), 64'd2);
    tx_before = tx_total;
    for (int i = 0; i < 20; i++) cycle("sim.stream", 1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
    check("sim.throughput", 64'(tx_total - tx_before), 64'd20);

    // Flush, then clear at count 3
    for (int i = 0; i < DEP + 1; i++) cycle("flush", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("clr.fill", 1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
    cycle("clr", 1'b0, '0, 1'b0, 1'b1);
    check("clr.ready_low", 64'(o_input_ready), 64'd0);
    cycle("clr.after", 1'b0, '0, 1'b1, 1'b0);
    check("clr.ready_up", 64'(o_input_ready), 64'd1);
    cycle("clr.new", 1'b1, DW'(32'h55), 1'b0, 1'b0);
    check("clr.data55", 64'(o_data), 64'h55);
    cycle("clr.out", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst
    cycle("ar.fill", 1'b1, DW'(32'hE0), 1'b0, 1'b0);
    cycle("ar.fill", 1'b1, DW'(32'hE1), 1'b0, 1'b0);
    #2;
    i_aresetn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge i_clock);
    #1;
    i_aresetn = 1'b1;
    cycle("ar.release", 1'b0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/skid_fifo.md
Name: skid_fifo

Overview:
- Parametrised successor to the single-entry skid buffer: a valid/ready elastic buffer with configurable capacity (DEPTH entries, output register included).
- Breaks combinational paths on both interfaces: o_input_ready, o_output_valid and o_data are all driven from flops.
- Adds occupancy count, full/empty flags, a programmable almost-full flag and a synchronous clear.
- Sits between pipeline stages or clock-enable domains where bursts must be absorbed without back-pressure bubbles.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 4, total storage entries including the output register; power of two, >=2.
- ALMOST_FULL_LEVEL, 3, o_almost_full asserts when count >= this value; range 1..DEPTH.

Ports:
- i_clock  input  1  clock; all state updates on the rising edge.
- i_aresetn  input  1  asynchronous, active-low reset.
- i_clear  input  1  synchronous flush, active-high.
- i_data  input  DATA_WIDTH  input payload.
- i_input_valid  input  1  upstream valid.
- o_input_ready  output  1  registered; buffer can accept.
- o_data  output  DATA_WIDTH  registered head-of-queue payload.
- o_output_valid  output  1  registered; o_data is valid.
- i_output_ready  input  1  downstream ready.
- o_count  output  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
- o_empty  output  1  registered; count==0.
- o_full  output  1  registered; count==DEPTH.
- o_almost_full  output  1  registered; count>=ALMOST_FULL_LEVEL.

Behaviour:
- Reset is i_aresetn, asynchronous, active-low; clock is i_clock.
- Reset values: o_data='0, o_output_valid=0, o_input_ready=0, o_count=0, o_empty=1, o_full=0, o_almost_full=0, and all storage '0.
  - o_input_ready rises on the first rising edge after i_aresetn deasserts.
- Handshakes:
  - accept = i_input_valid && o_input_ready.
  - transmit = o_output_valid && i_output_ready.
  - No combinational path from any input to any output.
- Count update: next_count = count + accept - transmit.
  - Accept and transmit in the same cycle leave the count unchanged.
- Registered flags, all derived from next_count:
  - o_input_ready <= (next_count != DEPTH).
  - o_output_valid <= (next_count != 0).
  - o_empty, o_full and o_almost_full follow the same rule.
- Organisation:
  - Output register plus a DEPTH-1 entry circular store.
  - Read/write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH-1 slots via an explicit compare, not a power-of-two mask.
- Data path cases:
  - Empty, accept: i_data loads directly into o_data. Latency is 1 cycle, with o_output_valid high after the accepting edge.
  - Output occupied, store empty, accept and transmit: i_data loads into o_data (bypass).
  - Output occupied, accept, no transmit: i_data is written to the store at the write pointer.
  - Transmit with a non-empty store: the store head moves into o_data and the read pointer advances. A simultaneous accept is written to the store in the same cycle.
  - Transmit with the store empty and no accept: o_output_valid falls and o_data holds its last value.
- Ordering: strict FIFO, no drops and no duplicates.
- Stability: while o_output_valid=1 and i_output_ready=0, o_data and o_output_valid must not change.
- Full: o_input_ready=0.
  - Upstream valid is ignored, so there is no overflow.
  - A transmit at full raises o_input_ready on the next cycle; there is no same-cycle pass-through.
- Empty: o_output_valid=0, and i_output_ready is ignored.
- i_clear has priority over accept/transmit. It takes the same values as reset on that edge (o_input_ready=0 for one cycle), and in-flight data is discarded.
- Asynchronous reset mid-burst: all outputs go to reset values immediately, without waiting for a clock edge.
- Sustained throughput: 1 word/cycle when input valid and output ready are both continuously high, from any non-full state.

Test Plan:
- Reset then idle: hold i_aresetn=0 for 3 cycles, then release. Expect o_input_ready=1 one edge after release, o_count=0, o_empty=1, o_data=0.
- Fill to full (DEPTH=4) with i_output_ready=0: send 0xA0..0xA3. Expect o_count to step 1,2,3,4, o_almost_full=1 at count 3, and o_full=1 with o_input_ready=0 after the 4th accept. A 5th word 0xA4 held valid is not accepted.
- Drain after full: set i_output_ready=1. Expect outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then o_output_valid=0 and o_empty=1. Expect o_input_ready=1 one cycle after the first transmit.
- Streaming with random back-pressure: 1000 words 0..999, random valid/ready at ~50% each. Expect in-order output with no loss and no duplicates, o_data stable while stalled, and o_count == scoreboard depth every cycle.
- Simultaneous accept and transmit at count 2: o_count stays 2 and order is preserved. Continuous valid/ready for 20 cycles must transfer 20 words.
- Clear mid-burst at count 3: pulse i_clear for 1 cycle. Expect o_count=0, o_output_valid=0 and o_input_ready=0 on the next cycle, then o_input_ready=1. Stale words never appear; a new word 0x55 emerges next.
